// File: rtl/mem_bank_arbiter_if.sv
// Request/response bundle between one requester (compute or DMA) and the bank arbiter.
// The requester drives the request fields; the arbiter returns ready and the routed read line.
interface mem_bank_arbiter_if #(
  parameter int AW         = 10,
  parameter int SBW        = 3,
  parameter int LINE_WIDTH = 400
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [SBW-1:0]        sb;
  logic [AW-1:0]         addr;
  logic [LINE_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [LINE_WIDTH-1:0] rdata;

  modport master (output valid, we, sb, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, sb, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/mem_bank_arbiter.sv
// Two-requester arbiter/sequencer for one bank of 1R+1W sub-banks.
// Round-robin per (port, sub-bank) on conflicts; read lines return via per-requester tag pipelines.
module mem_bank_arbiter #(
  parameter int SUBBANKS   = 8,
  parameter int LINE_WIDTH = 400,
  parameter int DEPTH      = 1024,
  parameter int AW         = $clog2(DEPTH),
  parameter int SBW        = $clog2(SUBBANKS),
  parameter int RD_LAT     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mem_bank_arbiter_if.slave              a,
  mem_bank_arbiter_if.slave              b,
  output logic [SUBBANKS-1:0]            we_bus,
  output logic [SUBBANKS*AW-1:0]         waddr_bus,
  output logic [SUBBANKS*LINE_WIDTH-1:0] wdata_bus,
  output logic [SUBBANKS-1:0]            re_bus,
  output logic [SUBBANKS*AW-1:0]         raddr_bus,
  input  logic [SUBBANKS*LINE_WIDTH-1:0] rdata_bus,
  output logic [15:0]                    conflict_cnt
);
  logic                                conflict_s;
  logic                                fav_b_s;
  logic                                a_ready_s;
  logic                                b_ready_s;
  logic [SUBBANKS-1:0]                 a_wr_s;
  logic [SUBBANKS-1:0]                 a_rd_s;
  logic [SUBBANKS-1:0]                 b_wr_s;
  logic [SUBBANKS-1:0]                 b_rd_s;
  logic [SUBBANKS-1:0][LINE_WIDTH-1:0] rdata_arr_s;

  // rr_r[port][sb] = 1 means the next conflict on that port/sub-bank goes to B
  logic [1:0][SUBBANKS-1:0]            rr_r;
  logic [15:0]                         conflict_cnt_r;
  logic [SUBBANKS-1:0]                 we_r;
  logic [SUBBANKS-1:0]                 re_r;
  logic [SUBBANKS-1:0][AW-1:0]         waddr_r;
  logic [SUBBANKS-1:0][AW-1:0]         raddr_r;
  logic [SUBBANKS-1:0][LINE_WIDTH-1:0] wdata_r;
  logic [RD_LAT:0]                     a_tv_r;
  logic [RD_LAT:0]                     b_tv_r;
  logic [RD_LAT:0][SBW-1:0]            a_tsb_r;
  logic [RD_LAT:0][SBW-1:0]            b_tsb_r;
  logic                                a_rvalid_r;
  logic                                b_rvalid_r;
  logic [LINE_WIDTH-1:0]               a_rdata_r;
  logic [LINE_WIDTH-1:0]               b_rdata_r;

  // Grant decision and per-sub-bank decode of the accepted requests
  always_comb begin
    conflict_s = a.valid & b.valid & (a.we == b.we) & (a.sb == b.sb);
    fav_b_s    = rr_r[a.we][a.sb];
    a_ready_s  = a.valid & (~conflict_s | ~fav_b_s);
    b_ready_s  = b.valid & (~conflict_s | fav_b_s);
    a_wr_s     = {SUBBANKS{1'b0}};
    a_rd_s     = {SUBBANKS{1'b0}};
    b_wr_s     = {SUBBANKS{1'b0}};
    b_rd_s     = {SUBBANKS{1'b0}};
    for (int i = 0; i < SUBBANKS; i++) begin
      a_wr_s[i] = a_ready_s &  a.we & (a.sb == SBW'(i));
      a_rd_s[i] = a_ready_s & ~a.we & (a.sb == SBW'(i));
      b_wr_s[i] = b_ready_s &  b.we & (b.sb == SBW'(i));
      b_rd_s[i] = b_ready_s & ~b.we & (b.sb == SBW'(i));
    end
  end

  // Round-robin pointers and saturating conflict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r           <= '0;
      conflict_cnt_r <= 16'h0000;
    end else if (conflict_s) begin
      rr_r[a.we][a.sb] <= ~rr_r[a.we][a.sb];
      if (conflict_cnt_r != 16'hFFFF) begin
        conflict_cnt_r <= conflict_cnt_r + 16'd1;
      end else begin
        conflict_cnt_r <= conflict_cnt_r;
      end
    end else begin
      rr_r           <= rr_r;
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  // Registered sub-bank ports: enables pulse, address/data hold between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= '0;
      re_r    <= '0;
      waddr_r <= '0;
      raddr_r <= '0;
      wdata_r <= '0;
    end else begin
      we_r <= a_wr_s | b_wr_s;
      re_r <= a_rd_s | b_rd_s;
      for (int i = 0; i < SUBBANKS; i++) begin
        if (a_wr_s[i]) begin
          waddr_r[i] <= a.addr;
          wdata_r[i] <= a.wdata;
        end else if (b_wr_s[i]) begin
          waddr_r[i] <= b.addr;
          wdata_r[i] <= b.wdata;
        end
        if (a_rd_s[i]) begin
          raddr_r[i] <= a.addr;
        end else if (b_rd_s[i]) begin
          raddr_r[i] <= b.addr;
        end
      end
    end
  end

  // Tag pipelines follow each read to its sub-bank output, then capture the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_tv_r     <= '0;
      b_tv_r     <= '0;
      a_tsb_r    <= '0;
      b_tsb_r    <= '0;
      a_rvalid_r <= 1'b0;
      b_rvalid_r <= 1'b0;
      a_rdata_r  <= '0;
      b_rdata_r  <= '0;
    end else begin
      a_tv_r     <= {a_tv_r[RD_LAT-1:0], a_ready_s & ~a.we};
      b_tv_r     <= {b_tv_r[RD_LAT-1:0], b_ready_s & ~b.we};
      a_tsb_r    <= {a_tsb_r[RD_LAT-1:0], a.sb};
      b_tsb_r    <= {b_tsb_r[RD_LAT-1:0], b.sb};
      a_rvalid_r <= a_tv_r[RD_LAT];
      b_rvalid_r <= b_tv_r[RD_LAT];
      if (a_tv_r[RD_LAT]) begin
        a_rdata_r <= rdata_arr_s[a_tsb_r[RD_LAT]];
      end
      if (b_tv_r[RD_LAT]) begin
        b_rdata_r <= rdata_arr_s[b_tsb_r[RD_LAT]];
      end
    end
  end

  assign rdata_arr_s  = rdata_bus;
  assign a.ready      = a_ready_s;
  assign b.ready      = b_ready_s;
  assign a.rvalid     = a_rvalid_r;
  assign b.rvalid     = b_rvalid_r;
  assign a.rdata      = a_rdata_r;
  assign b.rdata      = b_rdata_r;
  assign we_bus       = we_r;
  assign re_bus       = re_r;
  assign waddr_bus    = waddr_r;
  assign raddr_bus    = raddr_r;
  assign wdata_bus    = wdata_r;
  assign conflict_cnt = conflict_cnt_r;
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Randomized self-checking bench for mem_bank_arbiter with a simple sub-bank memory model
// and a rule-level reference model (per-port/sub-bank favour table, expected-return queue).
module tb_mem_bank_arbiter;
  localparam int SB     = 8;
  localparam int LW     = 400;
  localparam int DEPTH  = 1024;
  localparam int AW     = 10;
  localparam int SBW    = 3;
  localparam int RD_LAT = 2;

  typedef struct {
    int            req;
    int            cyc;
    logic [LW-1:0] data;
  } ret_t;

  logic clk;
  logic rst_n;
  logic [SB-1:0]    we_bus;
  logic [SB*AW-1:0] waddr_bus;
  logic [SB*LW-1:0] wdata_bus;
  logic [SB-1:0]    re_bus;
  logic [SB*AW-1:0] raddr_bus;
  logic [SB*LW-1:0] rdata_bus;
  logic [15:0]      conflict_cnt;

  mem_bank_arbiter_if #(.AW(AW), .SBW(SBW), .LINE_WIDTH(LW)) a_if ();
  mem_bank_arbiter_if #(.AW(AW), .SBW(SBW), .LINE_WIDTH(LW)) b_if ();

  mem_bank_arbiter #(
    .SUBBANKS(SB), .LINE_WIDTH(LW), .DEPTH(DEPTH), .AW(AW), .SBW(SBW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a_if), .b(b_if),
    .we_bus(we_bus), .waddr_bus(waddr_bus), .wdata_bus(wdata_bus),
    .re_bus(re_bus), .raddr_bus(raddr_bus), .rdata_bus(rdata_bus),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sub-bank storage seen by the DUT: read-old on same-cycle collision, RD_LAT output stages
  logic [LW-1:0] mem [SB][DEPTH];
  logic [LW-1:0] rpipe [RD_LAT][SB];
  always @(posedge clk) begin
    for (int i = 0; i < SB; i++) begin
      if (re_bus[i]) rpipe[0][i] <= mem[i][raddr_bus[i*AW +: AW]];
      if (we_bus[i]) mem[i][waddr_bus[i*AW +: AW]] = wdata_bus[i*LW +: LW];
    end
    for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  always_comb begin
    rdata_bus = '0;
    for (int i = 0; i < SB; i++) rdata_bus[i*LW +: LW] = rpipe[RD_LAT-1][i];
  end

  // Reference model state
  logic [LW-1:0] ref_mem [SB][DEPTH];
  bit            ref_fav [2][SB];
  int            ref_cnt;
  ret_t          exp_q [$];
  ret_t          obs_q [$];

  int n_cmp;
  int n_err;
  int cyc;
  bit got_a, got_b, exp_a, exp_b;
  logic [SB-1:0]    snap_we, snap_re;
  logic [SB*AW-1:0] snap_waddr, snap_raddr;
  logic [SB*LW-1:0] snap_wdata;
  logic [15:0]      snap_cnt;
  int               snap_exp_cnt;

  function automatic logic [LW-1:0] rand_line();
    logic [13*32-1:0] w;
    for (int i = 0; i < 13; i++) w[i*32 +: 32] = $urandom;
    return w[LW-1:0];
  endfunction

  // One clock cycle: drive, sample at negedge, advance the reference model
  task automatic step(input bit av, input bit aw, input int asb, input int aad, input logic [LW-1:0] awd,
                      input bit bv, input bit bw, input int bsb, input int bad, input logic [LW-1:0] bwd);
    bit conf;
    a_if.valid = av; a_if.we = aw; a_if.sb = asb[SBW-1:0]; a_if.addr = aad[AW-1:0]; a_if.wdata = awd;
    b_if.valid = bv; b_if.we = bw; b_if.sb = bsb[SBW-1:0]; b_if.addr = bad[AW-1:0]; b_if.wdata = bwd;
    @(negedge clk);
    got_a = a_if.ready; got_b = b_if.ready;
    snap_we = we_bus; snap_re = re_bus; snap_waddr = waddr_bus; snap_raddr = raddr_bus;
    snap_wdata = wdata_bus; snap_cnt = conflict_cnt; snap_exp_cnt = ref_cnt;
    if (a_if.rvalid) obs_q.push_back('{0, cyc, a_if.rdata});
    if (b_if.rvalid) obs_q.push_back('{1, cyc, b_if.rdata});
    conf  = av && bv && (aw == bw) && (asb == bsb);
    exp_a = av && (!conf || !ref_fav[aw][asb]);
    exp_b = bv && (!conf || ref_fav[aw][asb]);
    if (conf) begin
      ref_fav[aw][asb] = !ref_fav[aw][asb];
      if (ref_cnt < 65535) ref_cnt++;
    end
    if (exp_a && !aw) exp_q.push_back('{0, cyc + 2 + RD_LAT, ref_mem[asb][aad]});
    if (exp_b && !bw) exp_q.push_back('{1, cyc + 2 + RD_LAT, ref_mem[bsb][bad]});
    if (exp_a && aw) ref_mem[asb][aad] = awd;
    if (exp_b && bw) ref_mem[bsb][bad] = bwd;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, 0, 0, '0, 1'b0, 1'b0, 0, 0, '0);
  endtask

  task automatic model_reset();
    exp_q.delete(); obs_q.delete(); ref_cnt = 0;
    for (int p = 0; p < 2; p++) for (int s = 0; s < SB; s++) ref_fav[p][s] = 1'b0;
  endtask

  task automatic test_reset();
    step_idle();
    n_cmp++; if (got_a !== 1'b0 || got_b !== 1'b0) begin n_err++; $display("FAIL reset_ready: a=%0b b=%0b, expected 0 0", got_a, got_b); end
    n_cmp++; if (snap_we !== 8'h00 || snap_re !== 8'h00) begin n_err++; $display("FAIL reset_en: we=%h re=%h, expected 00 00", snap_we, snap_re); end
    n_cmp++; if (snap_waddr !== '0 || snap_raddr !== '0 || snap_wdata !== '0) begin n_err++; $display("FAIL reset_addr_data: nonzero address/data bus after reset"); end
    n_cmp++; if (snap_cnt !== 16'h0000) begin n_err++; $display("FAIL reset_cnt: %h, expected 0000", snap_cnt); end
    n_cmp++; if (a_if.rvalid !== 1'b0 || b_if.rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: a=%0b b=%0b, expected 0 0", a_if.rvalid, b_if.rvalid); end
    n_cmp++; if (a_if.rdata !== '0 || b_if.rdata !== '0) begin n_err++; $display("FAIL reset_rdata: nonzero read line after reset"); end
  endtask

  task automatic test_write_then_read();
    logic [LW-1:0] abc;
    ret_t e, o;
    int n;
    abc = {{33{12'hABC}}, 4'hA};
    n = cyc;
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b1, 3, 16, abc);
    n_cmp++; if (got_b !== 1'b1) begin n_err++; $display("FAIL wtr_b_ready: %0b, expected 1", got_b); end
    step_idle();
    n_cmp++; if (snap_we !== 8'h08 || snap_waddr[3*AW +: AW] !== 10'h010 || snap_wdata[3*LW +: LW] !== abc) begin
      n_err++; $display("FAIL wtr_we_pulse: we=%h waddr3=%h, expected we=08 waddr3=010 with ABC line", snap_we, snap_waddr[3*AW +: AW]); end
    step(1'b1, 1'b0, 3, 16, '0, 1'b0, 1'b0, 0, 0, '0);
    repeat (RD_LAT + 4) step_idle();
    n_cmp++; if (obs_q.size() == 0 || obs_q[0].cyc != n + 4 + RD_LAT || obs_q[0].data !== abc) begin
      n_err++; $display("FAIL wtr_return: %0d returns, first at cycle %0d, expected cycle %0d with ABC line", obs_q.size(), (obs_q.size() != 0) ? obs_q[0].cyc : -1, n + 4 + RD_LAT); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL wtr_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL wtr_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_conflict_rr();
    ret_t e, o;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 5, i, '0, 1'b1, 1'b0, 5, 100 + i, '0);
      n_cmp++; if (got_a !== (i % 2 == 0) || got_b !== (i % 2 == 1)) begin
        n_err++; $display("FAIL rr_grant%0d: a=%0b b=%0b, expected a=%0b b=%0b", i, got_a, got_b, (i % 2 == 0), (i % 2 == 1)); end
    end
    step_idle();
    n_cmp++; if (snap_cnt !== 16'd6) begin n_err++; $display("FAIL rr_cnt: %0d, expected 6", snap_cnt); end
    repeat (RD_LAT + 3) step_idle();
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL rr_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rr_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_rw_same_sb();
    ret_t e, o;
    step(1'b1, 1'b0, 2, 7, '0, 1'b1, 1'b1, 2, 9, rand_line());
    n_cmp++; if (got_a !== 1'b1 || got_b !== 1'b1) begin n_err++; $display("FAIL rw_ready: a=%0b b=%0b, expected 1 1", got_a, got_b); end
    step_idle();
    n_cmp++; if (snap_re !== 8'h04 || snap_we !== 8'h04 || snap_raddr[2*AW +: AW] !== 10'd7 || snap_waddr[2*AW +: AW] !== 10'd9) begin
      n_err++; $display("FAIL rw_pulse: re=%h we=%h raddr2=%0d waddr2=%0d, expected 04 04 7 9", snap_re, snap_we, snap_raddr[2*AW +: AW], snap_waddr[2*AW +: AW]); end
    repeat (RD_LAT + 3) step_idle();
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL rw_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rw_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_diff_sb();
    ret_t e, o;
    step(1'b1, 1'b0, 0, 3, '0, 1'b1, 1'b0, 7, 3, '0);
    n_cmp++; if (got_a !== 1'b1 || got_b !== 1'b1) begin n_err++; $display("FAIL diff_ready: a=%0b b=%0b, expected 1 1", got_a, got_b); end
    repeat (RD_LAT + 4) step_idle();
    n_cmp++; if (obs_q.size() != 2 || obs_q[0].cyc != obs_q[1].cyc) begin n_err++; $display("FAIL diff_same_cycle: %0d returns not in one cycle, expected 2 together", obs_q.size()); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL diff_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL diff_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
    n_cmp++; if (a_if.rdata !== ref_mem[0][3] || b_if.rdata !== ref_mem[7][3]) begin n_err++; $display("FAIL diff_hold: read lines not held after rvalid dropped"); end
  endtask

  task automatic test_random();
    ret_t e, o;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), rand_line(),
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 7), rand_line());
      n_cmp++; if (got_a !== exp_a || got_b !== exp_b) begin n_err++; $display("FAIL rand_ready cyc%0d: a=%0b b=%0b, expected a=%0b b=%0b", cyc - 1, got_a, got_b, exp_a, exp_b); end
    end
    repeat (RD_LAT + 4) step_idle();
    n_cmp++; if (snap_cnt !== 16'(snap_exp_cnt)) begin n_err++; $display("FAIL rand_cnt: %0d, expected %0d", snap_cnt, snap_exp_cnt); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL rand_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rand_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_reset_midflight();
    ret_t e, o;
    // Bias the read-port pointer of sb4 towards B so a reset that fails to clear it shows up
    step(1'b1, 1'b0, 4, 1, '0, 1'b1, 1'b0, 4, 2, '0);
    step(1'b1, 1'b0, 1, 5, '0, 1'b0, 1'b0, 0, 0, '0);
    step(1'b0, 1'b0, 0, 0, '0, 1'b1, 1'b0, 6, 5, '0);
    step(1'b1, 1'b0, 2, 5, '0, 1'b0, 1'b0, 0, 0, '0);
    a_if.valid = 1'b0; b_if.valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    repeat (RD_LAT + 6) step_idle();
    n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_no_rvalid: %0d returns after reset, expected 0", obs_q.size()); obs_q.delete(); end
    n_cmp++; if (a_if.rdata !== '0 || b_if.rdata !== '0 || snap_cnt !== 16'h0000) begin n_err++; $display("FAIL rst_outputs: cnt=%0d or read lines nonzero after reset", snap_cnt); end
    step(1'b1, 1'b0, 4, 8, '0, 1'b1, 1'b0, 4, 9, '0);
    n_cmp++; if (got_a !== 1'b1 || got_b !== 1'b0) begin n_err++; $display("FAIL rst_first_conflict: a=%0b b=%0b, expected 1 0", got_a, got_b); end
    repeat (RD_LAT + 3) step_idle();
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin n_err++; $display("FAIL rst_ret: got req%0d cyc%0d %h, expected req%0d cyc%0d %h", o.req, o.cyc, o.data, e.req, e.cyc, e.data); end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL rst_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  task automatic test_saturation();
    ret_t e, o;
    int   sbx;
    int   nprint;
    nprint = 0;
    for (int i = 0; i < 70000; i++) begin
      sbx = $urandom_range(0, 7);
      step(1'b1, 1'b0, sbx, $urandom_range(0, 1023), '0, 1'b1, 1'b0, sbx, $urandom_range(0, 1023), '0);
      n_cmp++;
      if (got_a !== exp_a || got_b !== exp_b || (got_a ^ got_b) !== 1'b1) begin
        n_err++;
        if (nprint < 20) begin nprint++; $display("FAIL sat_grant cyc%0d: a=%0b b=%0b, expected a=%0b b=%0b", cyc - 1, got_a, got_b, exp_a, exp_b); end
      end
    end
    repeat (RD_LAT + 4) step_idle();
    n_cmp++; if (snap_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt: %h, expected FFFF", snap_cnt); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o.req != e.req || o.cyc != e.cyc || o.data !== e.data) begin
        n_err++;
        if (nprint < 40) begin nprint++; $display("FAIL sat_ret: got req%0d cyc%0d, expected req%0d cyc%0d", o.req, o.cyc, e.req, e.cyc); end
      end
    end
    n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL sat_ret_count: %0d observed, %0d expected unmatched", obs_q.size(), exp_q.size()); exp_q.delete(); obs_q.delete(); end
  endtask

  initial begin
    logic [LW-1:0] line;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0;
    a_if.valid = 1'b0; a_if.we = 1'b0; a_if.sb = '0; a_if.addr = '0; a_if.wdata = '0;
    b_if.valid = 1'b0; b_if.we = 1'b0; b_if.sb = '0; b_if.addr = '0; b_if.wdata = '0;
    for (int s = 0; s < SB; s++) begin
      for (int ad = 0; ad < DEPTH; ad++) begin
        line = rand_line();
        mem[s][ad] = line;
        ref_mem[s][ad] = line;
      end
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_write_then_read();
    test_conflict_rr();
    test_rw_same_sb();
    test_diff_sb();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
